// File: rtl/cla64_seq_if.sv
// Bus bundle for the 64-bit add/sub sequencer: request channel, CLA stage
// operand/result wires, response channel and a state debug tap.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1; the producer holds valid and payload stable until that edge.
interface cla64_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        in_ci;
   logic        in_sub;
   logic [31:0] cla_a;
   logic [31:0] cla_b;
   logic        cla_ci;
   logic [31:0] cla_s;
   logic        cla_co;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_s;
   logic        out_co;
   logic        out_ovf;
   logic        out_zero;
   logic [2:0]  dbg_state;

   modport slave (
      input  in_valid, in_a, in_b, in_ci, in_sub, cla_s, cla_co, out_ready,
      output in_ready, cla_a, cla_b, cla_ci, out_valid, out_s, out_co,
             out_ovf, out_zero, dbg_state
   );

   modport master (
      output in_valid, in_a, in_b, in_ci, in_sub, cla_s, cla_co, out_ready,
      input  in_ready, cla_a, cla_b, cla_ci, out_valid, out_s, out_co,
             out_ovf, out_zero, dbg_state
   );
endinterface

// File: rtl/cla64_seq.sv
// Sequences one 64-bit add/sub through a registered 32-bit CLA stage as a
// low pass then a high pass, chaining the low carry into the high pass.
module cla64_seq #(
   parameter int CLA_LAT = 1
) (
   input logic        clock,
   input logic        reset_n,
   cla64_seq_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ISSUE_LO = 3'd1,
      WAIT_LO  = 3'd2,
      ISSUE_HI = 3'd3,
      WAIT_HI  = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_cnt;
   logic        w_wait_last;
   logic        w_in_ready;
   logic        w_out_valid;
   logic [63:0] w_b_eff;
   logic        w_c0;

   logic [63:0] r_a;
   logic [63:0] r_b;
   logic [31:0] r_lo_s;
   logic [31:0] r_cla_a;
   logic [31:0] r_cla_b;
   logic        r_cla_ci;
   logic [63:0] r_out_s;
   logic        r_out_co;
   logic        r_out_ovf;
   logic        r_out_zero;

   assign w_wait_last = (r_cnt == 3'(CLA_LAT - 1));
   // Subtraction is A + ~B + 1, so B is inverted once at accept time.
   assign w_b_eff     = bus.in_sub ? ~bus.in_b : bus.in_b;
   assign w_c0        = bus.in_sub ? 1'b1 : bus.in_ci;

   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_next = ISSUE_LO;
         end
         ISSUE_LO: w_next = WAIT_LO;
         WAIT_LO:  if (w_wait_last) w_next = ISSUE_HI;
         ISSUE_HI: w_next = WAIT_HI;
         WAIT_HI:  if (w_wait_last) w_next = DONE;
         DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_next = IDLE;
         end
         default:  w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_cnt      <= 3'd0;
         r_a        <= 64'd0;
         r_b        <= 64'd0;
         r_lo_s     <= 32'd0;
         r_cla_a    <= 32'd0;
         r_cla_b    <= 32'd0;
         r_cla_ci   <= 1'b0;
         r_out_s    <= 64'd0;
         r_out_co   <= 1'b0;
         r_out_ovf  <= 1'b0;
         r_out_zero <= 1'b0;
      end else begin
         if ((r_state == WAIT_LO) || (r_state == WAIT_HI))
            r_cnt <= w_wait_last ? 3'd0 : r_cnt + 3'd1;
         else
            r_cnt <= 3'd0;

         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a      <= bus.in_a;
                  r_b      <= w_b_eff;
                  r_cla_a  <= bus.in_a[31:0];
                  r_cla_b  <= w_b_eff[31:0];
                  r_cla_ci <= w_c0;
               end
            end
            WAIT_LO: begin
               // The low-pass carry goes straight into the high-pass carry-in.
               if (w_wait_last) begin
                  r_lo_s   <= bus.cla_s;
                  r_cla_a  <= r_a[63:32];
                  r_cla_b  <= r_b[63:32];
                  r_cla_ci <= bus.cla_co;
               end
            end
            WAIT_HI: begin
               if (w_wait_last) begin
                  r_out_s    <= {bus.cla_s, r_lo_s};
                  r_out_co   <= bus.cla_co;
                  r_out_ovf  <= (r_a[63] == r_b[63]) && (bus.cla_s[31] != r_a[63]);
                  r_out_zero <= ({bus.cla_s, r_lo_s} == 64'd0);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.cla_a     = r_cla_a;
   assign bus.cla_b     = r_cla_b;
   assign bus.cla_ci    = r_cla_ci;
   assign bus.out_s     = r_out_s;
   assign bus.out_co    = r_out_co;
   assign bus.out_ovf   = r_out_ovf;
   assign bus.out_zero  = r_out_zero;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_cla64_seq.sv
// Bench for cla64_seq: models the registered CLA stage, predicts each
// result from full 64-bit arithmetic, and scoreboards the response channel.
module tb_cla64_seq;
   localparam int TMO = 50;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   cla64_seq_if bus ();

   cla64_seq #(.CLA_LAT(1)) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [66:0] exp_q[$];
   logic [66:0] mon_exp;
   bit          mon_en = 1'b0;

   // Registered 32-bit CLA stage, one clock of latency.
   always @(posedge clock)
      {bus.cla_co, bus.cla_s} <= {1'b0, bus.cla_a} + {1'b0, bus.cla_b} + 33'(bus.cla_ci);

   task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic ci, input logic sub);
      logic [63:0] bb;
      logic [64:0] sum;
      logic        ovf;
      bb  = sub ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + 65'(sub ? 1'b1 : ci);
      ovf = (a[63] == bb[63]) && (sum[63] != a[63]);
      return {sum[63:0], sum[64], ovf, (sum[63:0] == 64'd0)};
   endfunction

   always @(negedge clock) begin
      if (mon_en && reset_n && bus.out_valid) begin
         check("vld_rdy_excl", 67'(bus.in_ready), 67'(0));
         if (bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 67'(bus.out_valid), 67'(0));
            end else begin
               mon_exp = exp_q.pop_front();
               check("result", {bus.out_s, bus.out_co, bus.out_ovf, bus.out_zero}, mon_exp);
            end
         end
      end
   end

   task automatic wait_in_ready();
      int t = 0;
      while (!bus.in_ready && t < TMO) begin
         @(negedge clock);
         t++;
      end
      if (!bus.in_ready) check("in_ready_timeout", 67'(bus.in_ready), 67'(1));
   endtask

   // Called at a negedge; returns at the negedge right after the accept edge.
   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sub);
      wait_in_ready();
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_ci    = ci;
      bus.in_sub   = sub;
      bus.in_valid = 1'b1;
      exp_q.push_back(model(a, b, ci, sub));
      @(posedge clock);
      @(negedge clock);
      bus.in_valid = 1'b0;
      bus.in_a     = {$urandom(), $urandom()};
      bus.in_b     = {$urandom(), $urandom()};
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < TMO) begin
         @(negedge clock);
         t++;
      end
      check("drain", 67'(exp_q.size()), 67'(0));
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_a      = 64'd0;
      bus.in_b      = 64'd0;
      bus.in_ci     = 1'b0;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_in_ready", 67'(bus.in_ready), 67'(1));
      check("rst_out_valid", 67'(bus.out_valid), 67'(0));
      check("rst_outs", {bus.out_s, bus.out_co, bus.out_ovf, bus.out_zero}, 67'(0));
      check("rst_cla", 67'({bus.cla_a, bus.cla_b, bus.cla_ci}), 67'(0));
      reset_n       = 1'b1;
      mon_en        = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clock);

      // All-ones plus carry-in: wraps to zero, latency and high-pass carry
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
      check("lat_n0_valid", 67'(bus.out_valid), 67'(0));
      check("busy_in_ready", 67'(bus.in_ready), 67'(0));
      @(negedge clock);
      @(negedge clock);
      check("hi_cla_ci", 67'(bus.cla_ci), 67'(1));
      check("hi_cla_ab", 67'({bus.cla_a, bus.cla_b}), 67'({32'hFFFF_FFFF, 32'h0}));
      @(negedge clock);
      check("lat_n3_valid", 67'(bus.out_valid), 67'(0));
      @(negedge clock);
      check("lat_n4_valid", 67'(bus.out_valid), 67'(1));
      drain();

      // Carry chained between halves
      send(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      @(negedge clock);
      @(negedge clock);
      check("chain_cla_ci", 67'(bus.cla_ci), 67'(1));
      drain();

      send(64'd5, 64'd7, 1'b0, 1'b1);
      drain();
      send(64'd7, 64'd5, 1'b1, 1'b1);
      drain();
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      drain();
      send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
      drain();

      // Stall in DONE while a second request waits
      bus.out_ready = 1'b0;
      send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
      begin
         int t = 0;
         while (!bus.out_valid && t < TMO) begin
            @(negedge clock);
            t++;
         end
      end
      bus.in_a     = 64'hDEAD_BEEF_0000_0001;
      bus.in_b     = 64'h0000_0001_FFFF_FFFF;
      bus.in_ci    = 1'b0;
      bus.in_sub   = 1'b1;
      bus.in_valid = 1'b1;
      repeat (5) begin
         check("stall_valid", 67'(bus.out_valid), 67'(1));
         check("stall_s", 67'(bus.out_s), 67'(model(64'h1234_5678_9ABC_DEF0,
                                                    64'h0FED_CBA9_8765_4321, 1'b1, 1'b0) >> 3));
         check("stall_in_ready", 67'(bus.in_ready), 67'(0));
         @(negedge clock);
      end
      exp_q.push_back(model(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, 1'b0, 1'b1));
      bus.out_ready = 1'b1;
      wait_in_ready();
      @(posedge clock);
      @(negedge clock);
      bus.in_valid = 1'b0;
      drain();

      // Reset during WAIT_HI aborts the operation
      send(64'hAAAA_AAAA_5555_5555, 64'h1111_1111_2222_2222, 1'b0, 1'b0);
      repeat (3) @(negedge clock);
      check("pre_rst_state", 67'(bus.dbg_state), 67'(4));
      reset_n = 1'b0;
      @(negedge clock);
      check("abort_in_ready", 67'(bus.in_ready), 67'(1));
      check("abort_out_valid", 67'(bus.out_valid), 67'(0));
      check("abort_outs", {bus.out_s, bus.out_co, bus.out_ovf, bus.out_zero}, 67'(0));
      check("abort_cla", 67'({bus.cla_a, bus.cla_b, bus.cla_ci}), 67'(0));
      exp_q.delete();
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
      check("abort_no_valid", 67'(bus.out_valid), 67'(0));
      send(64'h135F_A562_0000_0001, 64'h3561_4642_FFFF_FFFF, 1'b0, 1'b0);
      drain();

      // Random traffic with idle gaps and occasional response stalls
      for (int i = 0; i < 24; i++) begin
         logic [63:0] ra;
         logic [63:0] rb;
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         if (i % 6 == 0) rb = ~ra;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 6)) @(negedge clock);
         bus.out_ready = 1'b1;
         drain();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
